// File: rtl/pixel_ring_buffer_if.sv
// Handshake and observation bundle for the pixel ring buffer.
// The SPI/network side drives through master; the buffer itself uses slave.
interface pixel_ring_buffer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 72,
    parameter int unsigned TAPS  = 2
);
    localparam int unsigned POS_W = $clog2(DEPTH);

    logic                    clear;
    logic                    load_valid;
    logic [WIDTH-1:0]        load_data;
    logic                    load_ready;
    logic                    rotate_en;
    logic                    frame_ready;
    logic [POS_W-1:0]        position;
    logic                    frame_wrap;
    logic                    overrun;
    logic [TAPS*WIDTH-1:0]   tap_data;

    modport master (
        output clear, load_valid, load_data, rotate_en,
        input  load_ready, frame_ready, position, frame_wrap, overrun, tap_data
    );

    modport slave (
        input  clear, load_valid, load_data, rotate_en,
        output load_ready, frame_ready, position, frame_wrap, overrun, tap_data
    );
endinterface

// File: rtl/pixel_ring_buffer.sv
// Circular pixel shift chain: filled serially from the SPI side, then rotated
// losslessly from the network side while TAPS words at the output end are visible.
module pixel_ring_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 72,
    parameter int unsigned TAPS  = 2
) (
    input  logic                clk,
    input  logic                rst,
    pixel_ring_buffer_if.slave  bus
);
    localparam int unsigned POS_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               wrap_q, wrap_d;
    logic               overrun_q, overrun_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    // Next-state: clear wins; otherwise the state alone picks load vs rotate.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        wrap_d    = 1'b0;
        overrun_d = overrun_q;
        mem_d     = mem_q;

        if (bus.clear) begin
            state_d   = S_EMPTY;
            cnt_d     = '0;
            pos_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_EMPTY, S_LOADING: begin
                    if (bus.load_valid) begin
                        mem_d[0] = bus.load_data;
                        for (int i = 1; i < int'(DEPTH); i++) begin
                            mem_d[i] = mem_q[i-1];
                        end
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = (cnt_d == CNT_W'(DEPTH)) ? S_FULL : S_LOADING;
                    end
                end
                S_FULL: begin
                    if (bus.load_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.rotate_en) begin
                        mem_d[0] = mem_q[DEPTH-1];
                        for (int i = 1; i < int'(DEPTH); i++) begin
                            mem_d[i] = mem_q[i-1];
                        end
                        if (pos_q == POS_W'(DEPTH - 1)) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d  = pos_q + POS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            cnt_q     <= '0;
            pos_q     <= '0;
            wrap_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            wrap_q    <= wrap_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.load_ready  = (state_q != S_FULL);
    assign bus.frame_ready = (state_q == S_FULL);
    assign bus.position    = pos_q;
    assign bus.frame_wrap  = wrap_q;
    assign bus.overrun     = overrun_q;

    // Taps expose the last TAPS entries of the chain, tap 0 nearest the input end.
    for (genvar k = 0; k < int'(TAPS); k++) begin : g_tap
        assign bus.tap_data[k*WIDTH +: WIDTH] = mem_q[DEPTH-TAPS+k];
    end
endmodule

// File: doc/pixel_ring_buffer.md
PIXEL_RING_BUFFER -- requirements
Module: pixel_ring_buffer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: bits per pixel word.
REQ-002 The block SHALL take parameter DEPTH, default 72: number of pixel words stored; legal range 2..1024.
REQ-003 The block SHALL take parameter TAPS, default 2: number of parallel output taps; legal range 1..DEPTH.
REQ-004 The block SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port clear, input, 1: synchronous flush to empty.
REQ-007 The block SHALL have port load_valid, input, 1: load_data is valid this cycle.
REQ-008 The block SHALL have port load_data, input, WIDTH: pixel word from the SPI side.
REQ-009 The block SHALL have port load_ready, output, 1: buffer accepts a word this cycle.
REQ-010 The block SHALL have port rotate_en, input, 1: request one circular shift from the network side.
REQ-011 The block SHALL have port frame_ready, output, 1: all DEPTH words loaded.
REQ-012 The block SHALL have port position, output, clog2(DEPTH): rotation offset since the frame completed.
REQ-013 The block SHALL have port frame_wrap, output, 1: one-cycle pulse when position wraps to 0.
REQ-014 The block SHALL have port overrun, output, 1: sticky flag for a load attempted while full.
REQ-015 The block SHALL have port tap_data, output, TAPS*WIDTH: tap k occupies bits [k*WIDTH +: WIDTH] and equals entry DEPTH-TAPS+k.

Function
REQ-016 Storage SHALL be a DEPTH-entry shift chain, entry 0 at the input end and entry DEPTH-1 at the output end.
REQ-017 The block SHALL implement exactly three states: EMPTY, LOADING and FULL.
REQ-018 A load SHALL be accepted in a cycle when load_valid=1 and load_ready=1: every entry i moves to i+1, and load_data enters entry 0.
REQ-019 load_ready SHALL equal 1 in EMPTY and LOADING and 0 in FULL; it is combinational from state only.
REQ-020 A fill counter of clog2(DEPTH+1) bits SHALL increment on each accepted load.
REQ-021 EMPTY SHALL go to LOADING on the first accepted load.
REQ-022 LOADING SHALL go to FULL on the accepted load that brings the counter to DEPTH; frame_ready SHALL be 1 from the following cycle.
REQ-023 frame_ready SHALL equal 1 exactly when the state is FULL.
REQ-024 In FULL, rotate_en=1 SHALL shift every entry i to i+1 and move entry DEPTH-1 into entry 0 (lossless rotation), with position incremented modulo DEPTH.
REQ-025 frame_wrap SHALL pulse for one cycle, registered, in the cycle after a rotation that moves position from DEPTH-1 to 0.
REQ-026 rotate_en SHALL be ignored in EMPTY and LOADING: no shift and no position change.
REQ-027 load_valid in FULL SHALL leave data unchanged and SHALL set overrun to 1; overrun clears only on clear or rst.
REQ-028 With load_valid=1 and rotate_en=1 in the same cycle, the state SHALL decide: LOADING performs the load only, FULL performs the rotation only.
REQ-029 clear=1 SHALL take priority over all other inputs: state becomes EMPTY, and the counter, position, frame_wrap and overrun become 0.
REQ-030 clear SHALL leave entry contents unchanged, and they are don't-care until the next frame.
REQ-031 tap_data SHALL be a direct combinational view of storage with zero latency.

Reset
REQ-032 While rst=1, the block SHALL immediately force state EMPTY, all storage entries, the counter and position to 0, and frame_ready, frame_wrap and overrun to 0.
REQ-033 While rst=1, the block SHALL drive load_ready=1.
REQ-034 Assertion of rst mid-load or mid-rotation SHALL abandon the frame with no partial state retained.
REQ-035 The first accepted load after rst deassertion SHALL be taken on the first rising clk edge with rst=0.

Verification (DEPTH=72, WIDTH=8, TAPS=2 unless noted)
REQ-036 Stimulus: load words 0..71, one per cycle, after reset. Response: frame_ready rises the cycle after word 71; tap 0 = 1 and tap 1 = 0; load_ready = 0.
REQ-037 Stimulus: full frame, then 72 consecutive rotate_en pulses. Response: position runs 1..71, 0; one frame_wrap pulse; taps return to 1 and 0; no data lost.
REQ-038 Stimulus: full frame, then load_valid=1 with data 0xAA. Response: overrun = 1, storage unchanged, taps still 1 and 0.
REQ-039 Stimulus: rst asserted asynchronously after 30 loads. Response: outputs zero at once without a clock edge; a fresh 72-word load completes normally.
REQ-040 Stimulus: clear and rotate_en together in FULL. Response: next cycle state is EMPTY, position = 0, frame_ready = 0, no rotation.
REQ-041 Stimulus: parameter sweep DEPTH=4, TAPS=4, load 0x10..0x13. Response: tap k = 0x13-k, and a wrap occurs after 4 rotations.
